// File: rtl/systolic_pkg.sv
`default_nettype none
// ============================================================================
// Module      : systolic_pkg
// Description : Shared types and sizing helpers for the systolic sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package systolic_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        FEED  = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam int DEF_N     = 4;
    localparam int DEF_DW    = 4;
    localparam int FEED_LEN  = 2 * DEF_N - 1;
    localparam int DRAIN_LEN = DEF_N - 1;

    function automatic int feed_len(input int n);
        return 2 * n - 1;
    endfunction

    function automatic int drain_len(input int n);
        return n - 1;
    endfunction

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/systolic_opbuf.sv
`default_nettype none
// ============================================================================
// Module      : systolic_opbuf
// Description : N x N operand register file with N skewed read lanes.
// Revision    : 1.0 - initial release
// ============================================================================
module systolic_opbuf
    import systolic_pkg::*;
#(
    parameter int N         = DEF_N,
    parameter int DW        = DEF_DW,
    parameter int CW        = idx_w(DEF_N),
    parameter int TW        = 4,
    parameter bit TRANSPOSE = 1'b0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            wr_en,
    input  logic [CW-1:0]   wr_row,
    input  logic [CW-1:0]   wr_col,
    input  logic [DW-1:0]   wr_data,
    input  logic [TW-1:0]   rd_t,
    output logic [N*DW-1:0] rd_data
);

    logic [DW-1:0] r_mem [N][N];
    logic          w_in_range;

    // Indices past N only exist when N is not a power of two; drop those writes.
    assign w_in_range = ({1'b0, wr_row} < (CW+1)'(N)) && ({1'b0, wr_col} < (CW+1)'(N));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < N; r++) begin
                for (int c = 0; c < N; c++) begin
                    r_mem[r][c] <= '0;
                end
            end
        end else if (wr_en && w_in_range) begin
            r_mem[wr_row][wr_col] <= wr_data;
        end
    end

    for (genvar l = 0; l < N; l++) begin : g_lane
        logic signed [TW:0] w_d;
        logic               w_hit;
        logic [CW-1:0]      w_k;

        assign w_d   = $signed({1'b0, rd_t}) - $signed((TW+1)'(l));
        assign w_hit = !w_d[TW] && (w_d[TW-1:0] < TW'(N));
        assign w_k   = w_d[CW-1:0];

        if (TRANSPOSE) begin : g_col
            assign rd_data[l*DW +: DW] = w_hit ? r_mem[w_k][l] : '0;
        end else begin : g_row
            assign rd_data[l*DW +: DW] = w_hit ? r_mem[l][w_k] : '0;
        end
    end

endmodule
`default_nettype wire

// File: rtl/systolic_seq.sv
`default_nettype none
// ============================================================================
// Module      : systolic_seq
// Description : Operand store and skewed edge sequencer for an N x N
//               output-stationary systolic array.
//               Optional SYSTOLIC_ACC_EN adds start_acc (run without clear).
// Revision    : 1.0 - initial release
// ============================================================================
module systolic_seq
    import systolic_pkg::*;
#(
    parameter int N  = DEF_N,
    parameter int DW = DEF_DW,
    parameter int CW = idx_w(N)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            wr_en,
    input  logic            wr_sel,
    input  logic [CW-1:0]   wr_row,
    input  logic [CW-1:0]   wr_col,
    input  logic [DW-1:0]   wr_data,
    input  logic            start,
`ifdef SYSTOLIC_ACC_EN
    input  logic            start_acc,
`endif
    output logic            busy,
    output logic            done,
    output logic            arr_clr,
    output logic [N*DW-1:0] west_o,
    output logic [N*DW-1:0] north_o
);

    localparam int              c_tw         = $clog2(3 * N);
    localparam logic [c_tw-1:0] c_feed_last  = c_tw'(feed_len(N) - 1);
    localparam logic [c_tw-1:0] c_drain_last = c_tw'(drain_len(N) - 1);

    state_t          r_state;
    logic [c_tw-1:0] r_cnt;
    logic            r_busy;
    logic            r_done;
    logic            r_arr_clr;
    logic [N*DW-1:0] r_west;
    logic [N*DW-1:0] r_north;

    logic            w_start_acc;
    logic            w_we_a;
    logic            w_we_b;
    logic [N*DW-1:0] w_west;
    logic [N*DW-1:0] w_north;

`ifdef SYSTOLIC_ACC_EN
    assign w_start_acc = start_acc;
`else
    assign w_start_acc = 1'b0;
`endif

    assign w_we_a = wr_en && (r_state == IDLE) && !wr_sel;
    assign w_we_b = wr_en && (r_state == IDLE) &&  wr_sel;

    systolic_opbuf #(
        .N(N), .DW(DW), .CW(CW), .TW(c_tw), .TRANSPOSE(1'b0)
    ) u_opbuf_a (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (w_we_a),
        .wr_row  (wr_row),
        .wr_col  (wr_col),
        .wr_data (wr_data),
        .rd_t    (r_cnt),
        .rd_data (w_west)
    );

    systolic_opbuf #(
        .N(N), .DW(DW), .CW(CW), .TW(c_tw), .TRANSPOSE(1'b1)
    ) u_opbuf_b (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (w_we_b),
        .wr_row  (wr_row),
        .wr_col  (wr_col),
        .wr_data (wr_data),
        .rd_t    (r_cnt),
        .rd_data (w_north)
    );

    // Edge, clear and done registers trail the state by one cycle, which lines
    // the done pulse up with the final accumulate in PE(N-1,N-1).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_arr_clr <= 1'b1;
            r_west    <= '0;
            r_north   <= '0;
        end else begin
            r_arr_clr <= (r_state == CLEAR);
            r_done    <= (r_state == DONE);
            r_west    <= (r_state == FEED) ? w_west  : '0;
            r_north   <= (r_state == FEED) ? w_north : '0;

            case (r_state)
                IDLE: begin
                    r_cnt <= '0;
                    if (start) begin
                        r_state <= CLEAR;
                        r_busy  <= 1'b1;
                    end else if (w_start_acc) begin
                        r_state <= FEED;
                        r_busy  <= 1'b1;
                    end
                end
                CLEAR: begin
                    r_state <= FEED;
                    r_cnt   <= '0;
                end
                FEED: begin
                    if (r_cnt == c_feed_last) begin
                        r_state <= DRAIN;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                DRAIN: begin
                    if (r_cnt == c_drain_last) begin
                        r_state <= DONE;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                    r_cnt   <= '0;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                    r_cnt   <= '0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign busy    = r_busy;
    assign done    = r_done;
    assign arr_clr = r_arr_clr;
    assign west_o  = r_west;
    assign north_o = r_north;

endmodule
`default_nettype wire

// File: tb/tb_systolic_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_systolic_seq
// Description : Bench for systolic_seq with a behavioural 4x4 PE array and a
//               plain matrix-product reference.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_systolic_seq;

    localparam int N  = 4;
    localparam int DW = 4;

    logic        clk     = 1'b0;
    logic        rst_n   = 1'b0;
    logic        wr_en   = 1'b0;
    logic        wr_sel  = 1'b0;
    logic [1:0]  wr_row  = '0;
    logic [1:0]  wr_col  = '0;
    logic [3:0]  wr_data = '0;
    logic        start   = 1'b0;
`ifdef SYSTOLIC_ACC_EN
    logic        start_acc = 1'b0;
`endif
    logic        busy;
    logic        done;
    logic        arr_clr;
    logic [15:0] west_o;
    logic [15:0] north_o;

    int checks = 0;
    int errors = 0;

    int a_ref [N][N];
    int b_ref [N][N];
    int c_ref [N][N];

    logic [3:0]  pe_e   [N][N];
    logic [3:0]  pe_s   [N][N];
    logic [15:0] pe_acc [N][N];
    logic [3:0]  wi     [N][N];
    logic [3:0]  ni     [N][N];

    always #5 clk = ~clk;

    systolic_seq #(.N(N), .DW(DW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en     (wr_en),
        .wr_sel    (wr_sel),
        .wr_row    (wr_row),
        .wr_col    (wr_col),
        .wr_data   (wr_data),
        .start     (start),
`ifdef SYSTOLIC_ACC_EN
        .start_acc (start_acc),
`endif
        .busy      (busy),
        .done      (done),
        .arr_clr   (arr_clr),
        .west_o    (west_o),
        .north_o   (north_o)
    );

    // Attached array: each PE multiplies-accumulates and forwards east/south.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            wi[i][0] = west_o[i*4 +: 4];
            for (int j = 1; j < N; j++) wi[i][j] = pe_e[i][j-1];
        end
        for (int j = 0; j < N; j++) begin
            ni[0][j] = north_o[j*4 +: 4];
            for (int i = 1; i < N; i++) ni[i][j] = pe_s[i-1][j];
        end
    end

    always @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                if (arr_clr) begin
                    pe_acc[i][j] <= '0;
                    pe_e[i][j]   <= '0;
                    pe_s[i][j]   <= '0;
                end else begin
                    pe_acc[i][j] <= pe_acc[i][j] + 16'(wi[i][j]) * 16'(ni[i][j]);
                    pe_e[i][j]   <= wi[i][j];
                    pe_s[i][j]   <= ni[i][j];
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    // Edge value for a feed step t, straight from the skew rule.
    function automatic logic [15:0] exp_edge(input bit nrt, input int t);
        logic [15:0] v;
        v = '0;
        for (int l = 0; l < N; l++) begin
            int k;
            k = t - l;
            if (k >= 0 && k < N) v[l*4 +: 4] = nrt ? 4'(b_ref[k][l]) : 4'(a_ref[l][k]);
        end
        return v;
    endfunction

    task automatic write_op(input bit sel, input int r, input int c, input int d);
        @(negedge clk);
        wr_en   = 1'b1;
        wr_sel  = sel;
        wr_row  = 2'(r);
        wr_col  = 2'(c);
        wr_data = 4'(d);
    endtask

    // Everything except B[3][3], which each run writes alongside start.
    task automatic load();
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) write_op(1'b0, i, j, a_ref[i][j]);
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
                if (!(i == 3 && j == 3)) write_op(1'b1, i, j, b_ref[i][j]);
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic run(input bit acc, input bit inj_start, input bit inj_wr, input string tag);
        int s;
        s = acc ? 0 : 1;
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                int sum;
                sum = acc ? c_ref[i][j] : 0;
                for (int k = 0; k < N; k++) sum += a_ref[i][k] * b_ref[k][j];
                c_ref[i][j] = sum;
            end
        end
        @(negedge clk);
        wr_en   = 1'b1;
        wr_sel  = 1'b1;
        wr_row  = 2'd3;
        wr_col  = 2'd3;
        wr_data = 4'(b_ref[3][3]);
`ifdef SYSTOLIC_ACC_EN
        if (acc) start_acc = 1'b1;
        else     start     = 1'b1;
`else
        start = 1'b1;
`endif
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        start = 1'b0;
`ifdef SYSTOLIC_ACC_EN
        start_acc = 1'b0;
`endif
        for (int k = 0; k <= 16; k++) begin
            if (k > 0) begin
                @(posedge clk);
                #1;
                start = 1'b0;
                wr_en = 1'b0;
            end
            chk({tag, ".busy"},  32'(busy),    32'(k <= 10 + s));
            chk({tag, ".done"},  32'(done),    32'(k == 11 + s));
            chk({tag, ".clr"},   32'(arr_clr), 32'(s == 1 && k == 1));
            chk({tag, ".west"},  32'(west_o),  32'(exp_edge(1'b0, k - 1 - s)));
            chk({tag, ".north"}, 32'(north_o), 32'(exp_edge(1'b1, k - 1 - s)));
            if (k == 11 + s) begin
                for (int i = 0; i < N; i++)
                    for (int j = 0; j < N; j++)
                        chk($sformatf("%s.c%0d%0d", tag, i, j), 32'(pe_acc[i][j]), 32'(c_ref[i][j]));
            end
            if (inj_start && (k == 2 + s || k == 10 + s)) start = 1'b1;
            if (inj_wr && k == 2 + s) begin
                wr_en   = 1'b1;
                wr_sel  = 1'b0;
                wr_row  = 2'd0;
                wr_col  = 2'd0;
                wr_data = 4'd7;
            end
        end
    endtask

    task automatic fill_rand();
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                a_ref[i][j] = int'($urandom_range(0, 15));
                b_ref[i][j] = int'($urandom_range(0, 15));
            end
        end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst.busy",  32'(busy),    32'd0);
        chk("rst.done",  32'(done),    32'd0);
        chk("rst.clr",   32'(arr_clr), 32'd1);
        chk("rst.west",  32'(west_o),  32'd0);
        chk("rst.north", 32'(north_o), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rel.clr",  32'(arr_clr), 32'd0);
        chk("rel.busy", 32'(busy),    32'd0);

        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                a_ref[i][j] = (i == j) ? 1 : 0;
                b_ref[i][j] = 4 * i + j;
            end
        load();
        run(1'b0, 1'b0, 1'b0, "ident");

        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                a_ref[i][j] = 15;
                b_ref[i][j] = 15;
            end
        load();
        run(1'b0, 1'b0, 1'b0, "max");
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) a_ref[i][j] = 1;
        load();
        run(1'b0, 1'b0, 1'b0, "ones");

        for (int r = 0; r < 3; r++) begin
            fill_rand();
            load();
            run(1'b0, 1'b0, 1'b0, $sformatf("rand%0d", r));
        end

        fill_rand();
        a_ref[0][0] = 3;
        load();
        run(1'b0, 1'b1, 1'b0, "ign_start");
        run(1'b0, 1'b0, 1'b1, "ign_wr");
        run(1'b0, 1'b0, 1'b0, "after_wr");

        // Asynchronous reset in the middle of FEED.
        fill_rand();
        load();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("mid.busy",  32'(busy),    32'd0);
        chk("mid.done",  32'(done),    32'd0);
        chk("mid.clr",   32'(arr_clr), 32'd1);
        chk("mid.west",  32'(west_o),  32'd0);
        chk("mid.north", 32'(north_o), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
                chk($sformatf("mid.c%0d%0d", i, j), 32'(pe_acc[i][j]), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("mid.rel_clr", 32'(arr_clr), 32'd0);
        fill_rand();
        load();
        run(1'b0, 1'b0, 1'b0, "fresh");

`ifdef SYSTOLIC_ACC_EN
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                a_ref[i][j] = (i == j) ? 1 : 0;
                b_ref[i][j] = (i == j) ? 1 : 0;
            end
        load();
        run(1'b0, 1'b0, 1'b0, "acc_first");
        run(1'b1, 1'b0, 1'b0, "acc_second");
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
